// File: rtl/gpio_in_cond_irq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : gpio_in_cond_irq
// Brief    : GPIO input conditioning and interrupt stage. Synchronises the raw
//            pad inputs and optionally debounces them, depending on
//            `GPIO_IN_DEBOUNCE_EN. Detects per-pin rising and falling edges
//            into a write-1-to-clear status register and drives one
//            registered level interrupt. Registers are reached through a
//            Wishbone slave window.
// Config   : define GPIO_IN_DEBOUNCE_EN to build the prescaler and debounce
//            logic; otherwise the conditioned inputs are the synchronised
//            inputs, registered once.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_cond_irq #(
   parameter logic [31:0] DEFAULT_REG_VALUE = 32'hDEF_FAB_AC,
   parameter logic [15:0] DEB_DIV_RST       = 16'd1000,
   parameter int          DEB_SAMPLES       = 3
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_n_i,
   input  logic [16:0] WBs_ADR_i,
   input  logic        WBs_CYC_i,
   input  logic        WBs_STB_i,
   input  logic        WBs_WE_i,
   input  logic [3:0]  WBs_BYTE_STB_i,
   input  logic [31:0] WBs_DAT_i,
   output logic [31:0] WBs_DAT_o,
   output logic        WBs_ACK_o,
   input  logic [31:0] GPIO_raw_i,
   output logic [31:0] GPIO_in_o,
   output logic        IRQ_o
);

   // Word offsets, decoded from byte address bits [9:2]
   localparam logic [7:0] ADR_IN       = 8'h00;
   localparam logic [7:0] ADR_INT_EN   = 8'h01;
   localparam logic [7:0] ADR_RISE_EN  = 8'h02;
   localparam logic [7:0] ADR_FALL_EN  = 8'h03;
   localparam logic [7:0] ADR_INT_STAT = 8'h04;
   localparam logic [7:0] ADR_DEB_DIV  = 8'h05;

   logic [7:0]  reg_sel;
   logic        unused_adr;
   logic        ack;
   logic        access;
   logic        wr;
   logic [31:0] lane_mask;
   logic [31:0] wr_bits;

   logic [31:0] int_en;
   logic [31:0] rise_en;
   logic [31:0] fall_en;
   logic [31:0] int_stat;
   logic [31:0] w1c;
   logic [31:0] rise;
   logic [31:0] fall;
   logic        irq;

   logic [31:0] sync_meta;
   logic [31:0] sync;
   logic [31:0] stable;
   logic [31:0] stable_nxt;
   logic [31:0] prev;
   logic [31:0] deb_div_rd;

   assign reg_sel    = WBs_ADR_i[9:2];
   assign unused_adr = &{1'b0, WBs_ADR_i[16:10], WBs_ADR_i[1:0]};

   // One wait state per access: a write commits on the same edge that raises ACK
   assign access    = WBs_CYC_i & WBs_STB_i & ~ack;
   assign wr        = access & WBs_WE_i;
   assign lane_mask = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                       {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
   assign wr_bits   = WBs_DAT_i & lane_mask;

   // Acknowledge register: high for exactly one cycle per access
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) ack <= 1'b0;
      else              ack <= access;
   end

   // Enable registers with byte-lane qualified writes
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         int_en  <= '0;
         rise_en <= '0;
         fall_en <= '0;
      end else if (wr) begin
         if (reg_sel == ADR_INT_EN)  int_en  <= (int_en  & ~lane_mask) | wr_bits;
         if (reg_sel == ADR_RISE_EN) rise_en <= (rise_en & ~lane_mask) | wr_bits;
         if (reg_sel == ADR_FALL_EN) fall_en <= (fall_en & ~lane_mask) | wr_bits;
      end
   end

   // Two-flop synchroniser on the asynchronous pad inputs
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= GPIO_raw_i;
         sync      <= sync_meta;
      end
   end

`ifdef GPIO_IN_DEBOUNCE_EN
   logic [15:0] deb_div;
   logic [15:0] deb_cnt;
   logic        tick;
   logic        deb_div_wr;

   assign deb_div_wr = wr && (reg_sel == ADR_DEB_DIV);
   assign tick       = (deb_cnt == deb_div);
   assign deb_div_rd = {16'd0, deb_div};

   // Prescaler divider register; only the low 16 bits exist
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i)    deb_div <= DEB_DIV_RST;
      else if (deb_div_wr) deb_div <= (deb_div & ~lane_mask[15:0]) | wr_bits[15:0];
   end

   // Prescaler counter: 0..deb_div, restarted by any divider write
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i)    deb_cnt <= '0;
      else if (deb_div_wr) deb_cnt <= '0;
      else if (tick)       deb_cnt <= '0;
      else                 deb_cnt <= deb_cnt + 16'd1;
   end

   genvar gi;
   for (gi = 0; gi < 32; gi++) begin : g_deb
      logic [DEB_SAMPLES-1:0] hist;
      logic [DEB_SAMPLES-1:0] hist_nxt;

      assign hist_nxt = {hist[DEB_SAMPLES-2:0], sync[gi]};

      // Per-pin sample history, shifted once per prescaler tick
      always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
         if (!WBs_RST_n_i) hist <= '0;
         else if (tick)    hist <= hist_nxt;
      end

      // A new level is accepted only once the whole history agrees on it
      assign stable_nxt[gi] = (tick && (&hist_nxt))  ? 1'b1 :
                              (tick && ~(|hist_nxt)) ? 1'b0 : stable[gi];
   end
`else
   logic [31:0] unused_cfg;

   assign unused_cfg = {DEB_DIV_RST, 16'(DEB_SAMPLES)};
   assign stable_nxt = sync;
   assign deb_div_rd = 32'd0;
`endif

   // Conditioned level and its one-cycle-delayed copy for edge detection
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         stable <= '0;
         prev   <= '0;
      end else begin
         stable <= stable_nxt;
         prev   <= stable;
      end
   end

   assign rise = stable & ~prev & rise_en;
   assign fall = ~stable & prev & fall_en;
   assign w1c  = (wr && (reg_sel == ADR_INT_STAT)) ? wr_bits : 32'd0;

   // Sticky status: a new event in the same cycle as its clear keeps the bit set
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) int_stat <= '0;
      else              int_stat <= (int_stat & ~w1c) | rise | fall;
   end

   // Registered level interrupt from the enabled status bits
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) irq <= 1'b0;
      else              irq <= |(int_stat & int_en);
   end

   // Combinational read mux on the decoded word offset
   always_comb begin
      WBs_DAT_o = DEFAULT_REG_VALUE;
      case (reg_sel)
         ADR_IN:       WBs_DAT_o = stable;
         ADR_INT_EN:   WBs_DAT_o = int_en;
         ADR_RISE_EN:  WBs_DAT_o = rise_en;
         ADR_FALL_EN:  WBs_DAT_o = fall_en;
         ADR_INT_STAT: WBs_DAT_o = int_stat;
         ADR_DEB_DIV:  WBs_DAT_o = deb_div_rd;
         default:      WBs_DAT_o = DEFAULT_REG_VALUE;
      endcase
   end

   assign WBs_ACK_o = ack;
   assign GPIO_in_o = stable;
   assign IRQ_o     = irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_cond_irq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpio_in_cond_irq
// Brief    : Directed self-checking bench for gpio_in_cond_irq. Read results
//            are queued when the access is issued and compared on ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_in_cond_irq;

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam logic [31:0] DIV_RST_RD = 32'd1000;
   localparam logic [31:0] DIV_WR_RD  = 32'd4;
   localparam int          SETTLE     = 60;
`else
   localparam logic [31:0] DIV_RST_RD = 32'd0;
   localparam logic [31:0] DIV_WR_RD  = 32'd0;
   localparam int          SETTLE     = 6;
`endif
   localparam logic [3:0] ALL = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:0] adr;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  bs;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic [31:0] raw;
   logic [31:0] gpio_in;
   logic        irq;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic        irq_at_ack;

   gpio_in_cond_irq dut (
      .WBs_CLK_i      (clk),
      .WBs_RST_n_i    (rst_n),
      .WBs_ADR_i      (adr),
      .WBs_CYC_i      (cyc),
      .WBs_STB_i      (stb),
      .WBs_WE_i       (we),
      .WBs_BYTE_STB_i (bs),
      .WBs_DAT_i      (dat_w),
      .WBs_DAT_o      (dat_r),
      .WBs_ACK_o      (ack),
      .GPIO_raw_i     (raw),
      .GPIO_in_o      (gpio_in),
      .IRQ_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [16:0] a, input logic w, input logic [3:0] lanes,
                       input logic [31:0] d, input string tag);
      logic [31:0] e;
      adr = a; we = w; bs = lanes; dat_w = d; cyc = 1'b1; stb = 1'b1;
      cycles(1);
      chk({tag, "_ack"}, 32'(ack), 32'd1);
      irq_at_ack = irq;
      if (!w) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         chk({tag, "_rd"}, dat_r, e);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      cycles(1);
      chk({tag, "_ack_low"}, 32'(ack), 32'd0);
   endtask

   task automatic rd(input logic [16:0] a, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      xfer(a, 1'b0, ALL, 32'd0, tag);
   endtask

   task automatic wr(input logic [16:0] a, input logic [3:0] lanes, input logic [31:0] d,
                     input string tag);
      xfer(a, 1'b1, lanes, d, tag);
   endtask

   task automatic wait_gpio(input int b, input logic v, input int budget, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         cycles(1);
         if (gpio_in[b] === v) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before test end");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      bs = '0; dat_w = '0; raw = '0; irq_at_ack = 1'b0;
      cycles(3);
      chk("rst_ack",  32'(ack), 32'd0);
      chk("rst_irq",  32'(irq), 32'd0);
      chk("rst_gpio", gpio_in, 32'd0);
      rst_n = 1'b1;
      cycles(1);

      // Reset values of the register window
      rd(17'h00, 32'd0, "rd_in");
      rd(17'h04, 32'd0, "rd_int_en");
      rd(17'h10, 32'd0, "rd_stat");
      rd(17'h14, DIV_RST_RD, "rd_div");
      rd(17'h20, 32'hDEF_FAB_AC, "rd_dflt");
      wr(17'h14, ALL, 32'd4, "wr_div");
      rd(17'h14, DIV_WR_RD, "rd_div_wr");

      // Input latency / debounce
`ifdef GPIO_IN_DEBOUNCE_EN
      raw[5] = 1'b1;
      wait_gpio(5, 1'b1, 19, "deb_rise");
      begin
         logic seen;
         seen = 1'b0;
         raw[6] = 1'b1;
         for (int i = 0; i < 40; i++) begin
            if (i == 10) raw[6] = 1'b0;
            cycles(1);
            if (gpio_in[6] !== 1'b0) seen = 1'b1;
         end
         chk("deb_glitch", 32'(seen), 32'd0);
      end
`else
      raw[5] = 1'b1;
      cycles(2);
      chk("lat_early", 32'(gpio_in[5]), 32'd0);
      cycles(1);
      chk("lat_3clk", 32'(gpio_in[5]), 32'd1);
`endif

      // Rising edge interrupt and write-1-to-clear
      raw[5] = 1'b0;
      cycles(SETTLE);
      wr(17'h08, ALL, 32'h20, "wr_rise_en");
      wr(17'h04, ALL, 32'h20, "wr_int_en");
      rd(17'h10, 32'd0, "pre_rise_stat");
      raw[5] = 1'b1;
      cycles(SETTLE);
      rd(17'h10, 32'h20, "rise_stat");
      chk("rise_irq", 32'(irq), 32'd1);
      rd(17'h00, 32'h20, "rd_in_val");
      wr(17'h10, ALL, 32'h20, "w1c");
      chk("w1c_irq_lag", 32'(irq_at_ack), 32'd1);
      chk("w1c_irq", 32'(irq), 32'd0);
      rd(17'h10, 32'd0, "w1c_stat");

      // Falling edge, masked then unmasked
      wr(17'h0C, ALL, 32'h08, "wr_fall_en");
      wr(17'h04, ALL, 32'h00, "wr_int_en0");
      raw[3] = 1'b1;
      cycles(SETTLE);
      rd(17'h10, 32'd0, "fall_no_rise");
      raw[3] = 1'b0;
      cycles(SETTLE);
      rd(17'h10, 32'h08, "fall_stat");
      chk("fall_irq_masked", 32'(irq), 32'd0);
      wr(17'h04, ALL, 32'h08, "wr_int_en8");
      chk("en_irq_lag", 32'(irq_at_ack), 32'd0);
      chk("en_irq", 32'(irq), 32'd1);

      // Clear of bit 5 lands on the same edge that sets it
      raw[5] = 1'b0;
      cycles(SETTLE);
      raw[5] = 1'b1;
      wait_gpio(5, 1'b1, SETTLE, "coll_rise");
      wr(17'h10, ALL, 32'h20, "coll_w1c");
      rd(17'h10, 32'h28, "coll_stat");

      // Byte-lane qualified write
      wr(17'h08, ALL, 32'd0, "re_clr");
      wr(17'h08, 4'b0010, 32'hFFFF_FFFF, "lane_wr");
      rd(17'h08, 32'h0000_FF00, "lane_rd");

      // Reset asserted while ACK is high
      adr = 17'h04; we = 1'b1; bs = ALL; dat_w = 32'hFFFF_FFFF; cyc = 1'b1; stb = 1'b1;
      cycles(1);
      chk("mid_ack_pre", 32'(ack), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack",  32'(ack), 32'd0);
      chk("mid_rst_irq",  32'(irq), 32'd0);
      chk("mid_rst_gpio", gpio_in, 32'd0);
      chk("mid_rst_int_en", dat_r, 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = 17'h10; #1;
      chk("mid_rst_stat", dat_r, 32'd0);
      adr = 17'h08; #1;
      chk("mid_rst_rise_en", dat_r, 32'd0);
      adr = 17'h14; #1;
      chk("mid_rst_div", dat_r, DIV_RST_RD);
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpio_in_cond_irq.md
Name: gpio_in_cond_irq

Overview:
- Input-conditioning and interrupt stage that sits directly upstream of the GPIO control register block.
- Takes the raw 32-bit pad inputs, synchronises and optionally debounces them, and presents a clean GPIO_in vector to the control block.
- Detects rising and falling edges per pin, latches them into a write-1-to-clear status register, and raises one level interrupt.
- Has its own Wishbone slave window on the AHB-to-FPGA bridge.

Parameters:
- DEFAULT_REG_VALUE, 32'hDEF_FAB_AC, read value returned for unimplemented offsets.
- DEB_DIV_RST, 16'd1000, reset value of the debounce prescaler divider.
- DEB_SAMPLES, 3, number of consecutive equal ticked samples (2..4) needed to accept a new level.

Ports:
- WBs_CLK_i  in  1  Wishbone/FPGA clock; the only clock.
- WBs_RST_n_i  in  1  asynchronous active-low reset.
- WBs_ADR_i  in  17  byte address; bits [9:2] decoded.
- WBs_CYC_i  in  1  cycle select.
- WBs_STB_i  in  1  strobe.
- WBs_WE_i  in  1  write enable.
- WBs_BYTE_STB_i  in  4  byte lanes.
- WBs_DAT_i  in  32  write data.
- WBs_DAT_o  out  32  read data, combinational from address.
- WBs_ACK_o  out  1  registered acknowledge.
- GPIO_raw_i  in  32  asynchronous pad inputs.
- GPIO_in_o  out  32  conditioned inputs, fed to the GPIO control block.
- IRQ_o  out  1  level interrupt = |(INT_STAT & INT_EN), registered.

Behaviour:
- Reset (WBs_RST_n_i low, async): all registers 0, except DEB_DIV = DEB_DIV_RST. WBs_ACK_o=0, IRQ_o=0, GPIO_in_o=0, sync and debounce state 0.
- Register map (offset):
  - 0x00 IN: read-only conditioned inputs.
  - 0x04 INT_EN: R/W.
  - 0x08 RISE_EN: R/W.
  - 0x0C FALL_EN: R/W.
  - 0x10 INT_STAT: read; write-1-to-clear.
  - 0x14 DEB_DIV: R/W, bits[15:0]; upper bits read 0.
  - Any other offset reads DEFAULT_REG_VALUE; writes there are ignored.
- Writes are byte-lane qualified by WBs_BYTE_STB_i. W1C clears only bits in enabled lanes.
- ACK: WBs_ACK_o_nxt = CYC & STB & ~ACK, registered. Each access takes exactly one wait state: ACK high 1 cycle after STB, then low 1 cycle. Writes commit on the cycle where ACK is low.
- Synchroniser: 2-flop per bit on GPIO_raw_i, giving sync[31:0]. Latency 2 clocks.
- Prescaler: 16-bit counter counts 0..DEB_DIV and emits tick for one cycle on reaching DEB_DIV, then wraps to 0.
  - DEB_DIV=0: tick every cycle.
  - A write to DEB_DIV resets the counter to 0.
- Debounce, per pin, evaluated on tick:
  - Shift sync into a DEB_SAMPLES-deep history.
  - When all history bits are equal and differ from the stable bit, the stable bit takes the new value.
  - Pulses shorter than DEB_SAMPLES ticks never reach GPIO_in_o.
- GPIO_in_o = stable bits.
- Edge detect: registered previous stable value.
  - rise = stable & ~prev & RISE_EN; fall = ~stable & prev & FALL_EN.
  - Events set INT_STAT bits regardless of INT_EN. INT_EN masks only IRQ_o.
- Same-cycle set and W1C on one bit: the set wins (bit stays 1).
- IRQ_o updates 1 cycle after INT_STAT or INT_EN changes. A pin with both RISE_EN and FALL_EN set flags both edges.
- Reset asserted mid-operation clears everything immediately. After release, sync refills and stable=0, so a pin held high produces a rising event (if enabled) once debounce completes.

Optional Feature:
- Macro GPIO_IN_DEBOUNCE_EN.
- Defined: prescaler and debounce logic present as described.
- Undefined:
  - Prescaler and history registers are not built.
  - stable = sync directly, so input-to-GPIO_in_o latency is 3 clocks.
  - DEB_DIV reads 0 and writes to it are ignored.
  - Edge detection operates on sync.

Test Plan:
- Reset, then read 0x00/0x04/0x10/0x14/0x20 -> 0, 0, 0, 32'd1000, 32'hDEF_FAB_AC. Every access sees ACK exactly 1 cycle after STB.
- DEB_DIV=4, DEB_SAMPLES=3, raise raw[5] and hold -> GPIO_in_o[5]=1 within 2+3×5+2 clocks. A 2-tick glitch on raw[6] -> GPIO_in_o[6] stays 0.
- RISE_EN=0x20, INT_EN=0x20, raise raw[5] -> INT_STAT=0x20, IRQ_o=1. Write 0x20 to 0x10 -> INT_STAT=0, IRQ_o=0 next cycle.
- FALL_EN bit 3 set, INT_EN=0, falling edge on pin 3 -> INT_STAT=0x08, IRQ_o stays 0. Then set INT_EN=0x08 -> IRQ_o=1.
- Force W1C of bit 5 in the same cycle a new rising event on pin 5 is detected -> INT_STAT[5]=1.
- Byte-lane write of 0xFFFFFFFF to RISE_EN with BYTE_STB=4'b0010 -> readback 0x0000FF00. Assert reset mid-transfer -> ACK and all registers 0 immediately.
